// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM state types for the uart_driver peripheral
package uart_pkg;

    // out_bus status bit positions; rx_data occupies [7:0]
    localparam int OB_RX_VALID = 15;
    localparam int OB_TX_BUSY  = 14;
    localparam int OB_TX_FULL  = 13;
    localparam int OB_OVERRUN  = 12;
    localparam int OB_FERR     = 11;
    localparam int OB_RX_IE    = 10;
    localparam int OB_TX_IE    = 9;

    // in_bus bits of a control write
    localparam int CTL_WRITE   = 15;
    localparam int CTL_RX_IE   = 0;
    localparam int CTL_TX_IE   = 1;
    localparam int CTL_CLR_ERR = 2;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 receiver: 2-flop synchroniser plus mid-bit sampling FSM
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_push,
    output logic       rx_ferr
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    logic          sync1, sync2, prev;
    rx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            prev    <= 1'b1;
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            sync1   <= rx;
            sync2   <= sync1;
            prev    <= sync2;
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
        end
    end

    // push/ferr are combinational so the buffer captures the byte on the stop-sample edge
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        bit_n   = bit_idx;
        shift_n = shift;
        rx_push = 1'b0;
        rx_ferr = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_n = '0;
                if (prev && !sync2) state_n = RX_START;
            end
            RX_START: begin
                if (cnt == HALF_END) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == BIT_END) begin
                    cnt_n   = '0;
                    shift_n = {sync2, shift[7:1]};
                    bit_n   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == BIT_END) begin
                    cnt_n   = '0;
                    state_n = RX_IDLE;
                    rx_push = sync2;
                    rx_ferr = !sync2;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    assign rx_byte = shift;

endmodule

// File: rtl/uart_driver.sv
// rtl/uart_driver.sv - memory-mapped 8N1 UART: TX FSM, RX buffer, flags, bus decode; UART_RX_FIFO_EN selects a 4-entry RX FIFO
module uart_driver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] in_bus,
    output logic [15:0] out_bus,
    output logic        interrupt,
    output logic        uart_tx,
    input  logic        uart_rx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);

    logic          wr_data, wr_ctrl;
    logic          tx_full, tx_busy, tx_load;
    logic [7:0]    tx_hold, tx_shift, tx_shift_n;
    tx_state_t     tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_bit, tx_bit_n;
    logic          rx_ie, tx_ie, overrun, ferr;
    logic          rx_valid, pop, push_ok, ovr_set;
    logic [7:0]    rx_data, rx_byte;
    logic          rx_push, rx_ferr;
    logic          unused_bits;

    assign unused_bits = ^in_bus[14:8];
    assign wr_data     = write && !in_bus[CTL_WRITE] && !tx_full;
    assign wr_ctrl     = write && in_bus[CTL_WRITE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_hold  <= '0;
            tx_full  <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            if (tx_load) begin
                tx_full <= 1'b0;
            end else if (wr_data) begin
                tx_full <= 1'b1;
                tx_hold <= in_bus[7:0];
            end
        end
    end

    // STOP reloads straight into START when a byte is waiting, so frames run gap-free
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 1'b1;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_load    = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                if (tx_full) begin
                    tx_load    = 1'b1;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_END) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_state_n = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_END) begin
                    tx_cnt_n   = '0;
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    tx_bit_n   = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) tx_state_n = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_END) begin
                    tx_cnt_n = '0;
                    if (tx_full) begin
                        tx_load    = 1'b1;
                        tx_state_n = TX_START;
                    end else begin
                        tx_state_n = TX_IDLE;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
        if (tx_load) tx_shift_n = tx_hold;
    end

    always_comb begin
        uart_tx = 1'b1;
        if (tx_state == TX_START)     uart_tx = 1'b0;
        else if (tx_state == TX_DATA) uart_tx = tx_shift[0];
    end

    assign tx_busy = (tx_state != TX_IDLE);

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk    (clk),
        .rst    (rst),
        .rx     (uart_rx),
        .rx_byte(rx_byte),
        .rx_push(rx_push),
        .rx_ferr(rx_ferr)
    );

`ifdef UART_RX_FIFO_EN
    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] count;

    assign rx_valid = (count != 3'd0);
    assign pop      = read && rx_valid;
    assign push_ok  = rx_push && ((count != 3'd4) || pop);
    assign ovr_set  = rx_push && (count == 3'd4) && !pop;
    assign rx_data  = rx_valid ? fifo_mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= rx_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 2'd1;
            if (pop)     rd_ptr <= rd_ptr + 2'd1;
            if (push_ok && !pop)      count <= count + 3'd1;
            else if (pop && !push_ok) count <= count - 3'd1;
        end
    end
`else
    logic [7:0] rx_buf;
    logic       rx_hold_valid;

    assign rx_valid = rx_hold_valid;
    assign pop      = read && rx_valid;
    assign push_ok  = rx_push && (!rx_valid || pop);
    assign ovr_set  = rx_push && rx_valid && !read;
    assign rx_data  = rx_valid ? rx_buf : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_buf        <= '0;
            rx_hold_valid <= 1'b0;
        end else if (push_ok) begin
            rx_buf        <= rx_byte;
            rx_hold_valid <= 1'b1;
        end else if (pop) begin
            rx_hold_valid <= 1'b0;
        end
    end
`endif

    // a new error in the same cycle as a clear wins so it is never lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ie   <= 1'b0;
            tx_ie   <= 1'b0;
            overrun <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                rx_ie <= in_bus[CTL_RX_IE];
                tx_ie <= in_bus[CTL_TX_IE];
            end
            if (ovr_set)                             overrun <= 1'b1;
            else if (wr_ctrl && in_bus[CTL_CLR_ERR]) overrun <= 1'b0;
            if (rx_ferr)                             ferr <= 1'b1;
            else if (wr_ctrl && in_bus[CTL_CLR_ERR]) ferr <= 1'b0;
        end
    end

    always_comb begin
        out_bus              = '0;
        out_bus[OB_RX_VALID] = rx_valid;
        out_bus[OB_TX_BUSY]  = tx_busy;
        out_bus[OB_TX_FULL]  = tx_full;
        out_bus[OB_OVERRUN]  = overrun;
        out_bus[OB_FERR]     = ferr;
        out_bus[OB_RX_IE]    = rx_ie;
        out_bus[OB_TX_IE]    = tx_ie;
        out_bus[7:0]         = rx_data;
    end

    assign interrupt = (rx_ie & rx_valid) | (tx_ie & ~tx_busy & ~tx_full);

endmodule

// File: tb/tb_uart_driver.sv
// tb/tb_uart_driver.sv - scoreboard bench for uart_driver with CLKS_PER_BIT=4
module tb_uart_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [15:0] in_bus = '0;
    logic [15:0] out_bus;
    logic        interrupt;
    logic        uart_tx;
    logic        uart_rx = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_exp[$];
    int tx_starts[$];

    uart_driver #(.CLKS_PER_BIT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .read     (read),
        .write    (write),
        .in_bus   (in_bus),
        .out_bus  (out_bus),
        .interrupt(interrupt),
        .uart_tx  (uart_tx),
        .uart_rx  (uart_rx)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // TX monitor: captures 40 one-per-cycle samples from each start bit
    initial begin : tx_mon
        logic        prev;
        logic        aborted;
        logic [7:0]  b;
        logic [39:0] exp_w, got_w;
        logic [9:0]  frame;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev = 1'b1;
            end else if (prev && uart_tx === 1'b0) begin
                tx_starts.push_back(cyc);
                if (tx_q.size() == 0) begin
                    chk("tx_unexpected_frame", 64'(tx_q.size()), 64'd1);
                    b = 8'h00;
                end else begin
                    b = tx_q.pop_front();
                end
                frame   = {1'b1, b, 1'b0};
                aborted = 1'b0;
                for (int j = 0; j < 40; j++) begin
                    if (j > 0) begin
                        @(negedge clk);
                        #1;
                    end
                    if (rst) aborted = 1'b1;
                    exp_w[j] = frame[j / 4];
                    got_w[j] = uart_tx;
                end
                if (!aborted) chk("tx_frame", 64'(got_w), 64'(exp_w));
                prev = 1'b1;
            end else begin
                prev = uart_tx;
            end
        end
    end

    // RX monitor: every read cycle pops one expected byte
    initial forever begin
        @(negedge clk);
        #1;
        if (read === 1'b1) begin
            if (rx_exp.size() == 0)
                chk("rx_read_empty", 64'(out_bus[15]), 64'd0);
            else
                chk("rx_read", 64'({out_bus[15], out_bus[7:0]}), 64'({1'b1, rx_exp.pop_front()}));
        end
    end

    task automatic write_bus(input logic [15:0] v);
        @(negedge clk);
        write  = 1'b1;
        in_bus = v;
        @(negedge clk);
        write  = 1'b0;
        in_bus = '0;
    endtask

    task automatic read_bus();
        @(negedge clk);
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (4) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_uart_tx", 64'(uart_tx), 64'd1);
        chk("reset_out_bus", 64'(out_bus), 64'h0000);
        chk("reset_interrupt", 64'(interrupt), 64'd0);

        // single byte and load latency
        tx_q.push_back(8'hA5);
        write_bus(16'h00A5);
        #1;
        chk("tx_full_after_write", 64'(out_bus[14:13]), 64'b01);
        chk("tx_idle_line_after_write", 64'(uart_tx), 64'd1);
        @(negedge clk);
        #1;
        chk("tx_start_edge", 64'(uart_tx), 64'd0);
        chk("tx_busy_loaded", 64'(out_bus[14:13]), 64'b10);
        repeat (45) @(negedge clk);
        #1;
        chk("tx_done_idle", 64'(out_bus[14:13]), 64'b00);

        // back-to-back bytes plus a write dropped while holding register is full
        tx_q.push_back(8'h3C);
        write_bus(16'h003C);
        repeat (2) @(negedge clk);
        tx_q.push_back(8'hC3);
        write_bus(16'h00C3);
        write_bus(16'h0077);
        #1;
        chk("tx_full_held", 64'(out_bus[13]), 64'd1);
        repeat (90) @(negedge clk);
        #1;
        chk("tx_starts_count", 64'(tx_starts.size()), 64'd3);
        if (tx_starts.size() >= 3)
            chk("tx_back_to_back_gap", 64'(tx_starts[2] - tx_starts[1]), 64'd40);

        // receive and read
        send_rx(8'h3C, 1'b1);
        #1;
        chk("rx_before_read", 64'(out_bus & 16'h80FF), 64'h803C);
        rx_exp.push_back(8'h3C);
        read_bus();
        #1;
        chk("rx_after_read_valid", 64'(out_bus[15]), 64'd0);
        read_bus();

        // two frames without a read
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        #1;
`ifdef UART_RX_FIFO_EN
        chk("rx_two_no_overrun", 64'(out_bus & 16'h90FF), 64'h8011);
        rx_exp.push_back(8'h11);
        rx_exp.push_back(8'h22);
        read_bus();
        read_bus();
`else
        chk("rx_two_overrun", 64'(out_bus & 16'h90FF), 64'h9011);
        rx_exp.push_back(8'h11);
        read_bus();
`endif
        #1;
        chk("rx_drained", 64'(out_bus[15]), 64'd0);
        write_bus(16'h8004);
        #1;
        chk("clear_overrun", 64'(out_bus), 64'h0000);

        // framing error
        send_rx(8'h5A, 1'b0);
        #1;
        chk("rx_ferr_set", 64'(out_bus), 64'h0800);
        write_bus(16'h8004);
        #1;
        chk("rx_ferr_cleared", 64'(out_bus), 64'h0000);

        // interrupts
        write_bus(16'h8001);
        #1;
        chk("rx_ie_set", 64'(out_bus), 64'h0400);
        chk("irq_rx_empty", 64'(interrupt), 64'd0);
        send_rx(8'h55, 1'b1);
        #1;
        chk("irq_rx_pending", 64'(interrupt), 64'd1);
        chk("rx_55_status", 64'(out_bus), 64'h8455);
        rx_exp.push_back(8'h55);
        read_bus();
        #1;
        chk("irq_rx_cleared", 64'(interrupt), 64'd0);
        write_bus(16'h8002);
        #1;
        chk("irq_tx_idle", 64'(interrupt), 64'd1);
        chk("tx_ie_status", 64'(out_bus), 64'h0200);
        write_bus(16'h8000);
        #1;
        chk("irq_off", 64'(interrupt), 64'd0);

        // asynchronous reset in the middle of a frame
        tx_q.push_back(8'h00);
        write_bus(16'h0000);
        repeat (12) @(negedge clk);
        #1;
        chk("tx_mid_frame_low", 64'(uart_tx), 64'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_uart_tx_async", 64'(uart_tx), 64'd1);
        chk("rst_out_bus", 64'(out_bus), 64'h0000);
        chk("rst_interrupt", 64'(interrupt), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        #1;
        chk("post_rst_idle", 64'(uart_tx), 64'd1);
        chk("tx_queue_empty", 64'(tx_q.size()), 64'd0);
        chk("rx_queue_empty", 64'(rx_exp.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
